// File: rtl/riscv_apb_arb.sv
// Two-master (instruction fetch, load/store) to one-slave APB arbiter.
// Each requester sees a plain APB slave. The arbiter runs the downstream
// SETUP/ACCESS phases for the granted requester. Only that requester
// receives pready/prdata/pslverr.
module riscv_apb_arb #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter bit LS_PRIO = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    // instruction-fetch requester
    input  logic                  if_psel_i,
    input  logic [ADDR_W-1:0]     if_paddr_i,
    output logic                  if_pready_o,
    output logic [DATA_W-1:0]     if_prdata_o,
    output logic                  if_pslverr_o,
    // load/store requester
    input  logic                  ls_psel_i,
    input  logic [ADDR_W-1:0]     ls_paddr_i,
    input  logic                  ls_pwrite_i,
    input  logic [DATA_W-1:0]     ls_pwdata_i,
    input  logic [DATA_W/8-1:0]   ls_pstrb_i,
    output logic                  ls_pready_o,
    output logic [DATA_W-1:0]     ls_prdata_o,
    output logic                  ls_pslverr_o,
    // downstream APB master port
    output logic                  m_psel_o,
    output logic                  m_penable_o,
    output logic [ADDR_W-1:0]     m_paddr_o,
    output logic                  m_pwrite_o,
    output logic [DATA_W-1:0]     m_pwdata_o,
    output logic [DATA_W/8-1:0]   m_pstrb_o,
    input  logic                  m_pready_i,
    input  logic [DATA_W-1:0]     m_prdata_i,
    input  logic                  m_pslverr_i,
    // registered grant {ls, if}
    output logic [1:0]            gnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] gnt_q, gnt_d;          // {ls, if}
    logic       last_ls_q, last_ls_d;  // 1 = LS was served most recently
    logic       cand_if, cand_ls;      // requesters eligible at this arbitration point
    logic [1:0] pick;                  // arbitration winner, one-hot {ls, if} or 0
    logic       done;                  // downstream transfer completes this cycle

    // A reset cycle abandons the transfer, so no completion is reported in it.
    assign done = (state_q == ST_ACCESS) && m_pready_i && reset_n;

    // Pick a winner; a completing requester still holds psel, so it is excluded.
    always_comb begin
        cand_if = if_psel_i;
        cand_ls = ls_psel_i;
        if (state_q == ST_ACCESS) begin
            cand_if = if_psel_i & ~gnt_q[0];
            cand_ls = ls_psel_i & ~gnt_q[1];
        end
        pick = 2'b00;
        if (cand_if && cand_ls) begin
            pick = (LS_PRIO || !last_ls_q) ? 2'b10 : 2'b01;
        end else if (cand_ls) begin
            pick = 2'b10;
        end else if (cand_if) begin
            pick = 2'b01;
        end
    end

    // Next-state logic for the downstream phase sequencer and the grant.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        last_ls_d = last_ls_q;
        case (state_q)
            ST_IDLE: begin
                if (pick != 2'b00) begin
                    state_d = ST_SETUP;
                    gnt_d   = pick;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (m_pready_i) begin
                    last_ls_d = gnt_q[1];
                    gnt_d     = pick;
                    state_d   = (pick != 2'b00) ? ST_SETUP : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

    // State, grant and last-served registers; IF wins the first tie after reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            gnt_q     <= 2'b00;
            last_ls_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            last_ls_q <= last_ls_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign m_psel_o    = (state_q != ST_IDLE);
    assign m_penable_o = (state_q == ST_ACCESS);

    // Downstream request mux; IF is read-only so its write fields are forced low.
    always_comb begin
        m_paddr_o  = '0;
        m_pwrite_o = 1'b0;
        m_pwdata_o = '0;
        m_pstrb_o  = '0;
        if (state_q != ST_IDLE) begin
            if (gnt_q[1]) begin
                m_paddr_o  = ls_paddr_i;
                m_pwrite_o = ls_pwrite_i;
                m_pwdata_o = ls_pwdata_i;
                m_pstrb_o  = ls_pstrb_i;
            end else if (gnt_q[0]) begin
                m_paddr_o  = if_paddr_i;
            end
        end
    end

    // Response steering: only the granted requester sees the completion.
    always_comb begin
        if_pready_o  = done & gnt_q[0];
        ls_pready_o  = done & gnt_q[1];
        if_prdata_o  = if_pready_o ? m_prdata_i  : '0;
        if_pslverr_o = if_pready_o ? m_pslverr_i : 1'b0;
        ls_prdata_o  = ls_pready_o ? m_prdata_i  : '0;
        ls_pslverr_o = ls_pready_o ? m_pslverr_i : 1'b0;
    end

    // A granted requester must keep psel high for the whole transfer.
    if_hold_a: assert property (@(posedge clk) disable iff (!reset_n)
        ((state_q != ST_IDLE) && gnt_q[0]) |-> if_psel_i);
    ls_hold_a: assert property (@(posedge clk) disable iff (!reset_n)
        ((state_q != ST_IDLE) && gnt_q[1]) |-> ls_psel_i);

endmodule

// File: tb/tb_riscv_apb_arb.sv
// Bench for riscv_apb_arb. Two instances (round-robin and LS-priority) share
// stimulus; the unselected one is held in reset. Requester drivers push the
// expected responses into per-requester queues, and a negedge monitor checks
// the downstream bus against a transfer-level model and pops the queues.
`timescale 1ns/1ps
module tb_riscv_apb_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        sel;                 // 0: round-robin instance, 1: LS-priority instance
    logic        if_psel;
    logic [31:0] if_paddr;
    logic        ls_psel, ls_pwrite;
    logic [31:0] ls_paddr, ls_pwdata;
    logic [3:0]  ls_pstrb;
    logic        m_pready;
    logic [31:0] m_prdata;
    logic        m_pslverr;

    logic        d_if_pready  [2];
    logic [31:0] d_if_prdata  [2];
    logic        d_if_pslverr [2];
    logic        d_ls_pready  [2];
    logic [31:0] d_ls_prdata  [2];
    logic        d_ls_pslverr [2];
    logic        d_psel       [2];
    logic        d_penable    [2];
    logic [31:0] d_paddr      [2];
    logic        d_pwrite     [2];
    logic [31:0] d_pwdata     [2];
    logic [3:0]  d_pstrb      [2];
    logic [1:0]  d_gnt        [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            riscv_apb_arb #(.ADDR_W(32), .DATA_W(32), .LS_PRIO(gi == 1)) u_dut (
                .clk          (clk),
                .reset_n      (reset_n && (int'(sel) == gi)),
                .if_psel_i    (if_psel),
                .if_paddr_i   (if_paddr),
                .if_pready_o  (d_if_pready[gi]),
                .if_prdata_o  (d_if_prdata[gi]),
                .if_pslverr_o (d_if_pslverr[gi]),
                .ls_psel_i    (ls_psel),
                .ls_paddr_i   (ls_paddr),
                .ls_pwrite_i  (ls_pwrite),
                .ls_pwdata_i  (ls_pwdata),
                .ls_pstrb_i   (ls_pstrb),
                .ls_pready_o  (d_ls_pready[gi]),
                .ls_prdata_o  (d_ls_prdata[gi]),
                .ls_pslverr_o (d_ls_pslverr[gi]),
                .m_psel_o     (d_psel[gi]),
                .m_penable_o  (d_penable[gi]),
                .m_paddr_o    (d_paddr[gi]),
                .m_pwrite_o   (d_pwrite[gi]),
                .m_pwdata_o   (d_pwdata[gi]),
                .m_pstrb_o    (d_pstrb[gi]),
                .m_pready_i   (m_pready),
                .m_prdata_i   (m_prdata),
                .m_pslverr_i  (m_pslverr),
                .gnt_o        (d_gnt[gi])
            );
        end
    endgenerate

    // Outputs of the instance under test.
    logic        b_if_pready, b_if_pslverr, b_ls_pready, b_ls_pslverr;
    logic [31:0] b_if_prdata, b_ls_prdata, b_paddr, b_pwdata;
    logic        b_psel, b_penable, b_pwrite;
    logic [3:0]  b_pstrb;
    logic [1:0]  b_gnt;
    assign b_if_pready  = d_if_pready[sel];
    assign b_if_prdata  = d_if_prdata[sel];
    assign b_if_pslverr = d_if_pslverr[sel];
    assign b_ls_pready  = d_ls_pready[sel];
    assign b_ls_prdata  = d_ls_prdata[sel];
    assign b_ls_pslverr = d_ls_pslverr[sel];
    assign b_psel       = d_psel[sel];
    assign b_penable    = d_penable[sel];
    assign b_paddr      = d_paddr[sel];
    assign b_pwrite     = d_pwrite[sel];
    assign b_pwdata     = d_pwdata[sel];
    assign b_pstrb      = d_pstrb[sel];
    assign b_gnt        = d_gnt[sel];

    // Slave memory image: a fixed word at 0x100, a hash elsewhere.
    function automatic logic [31:0] rd_data(input logic [31:0] a);
        if (a == 32'h100) return 32'h0000_0013;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Slave flags an error for any address whose bits [7:4] are 0xE.
    function automatic logic err_f(input logic [31:0] a);
        return (a[7:4] == 4'hE);
    endfunction

    assign m_prdata  = rd_data(b_paddr);
    assign m_pslverr = err_f(b_paddr);

    int checks = 0;
    int errors = 0;
    logic [32:0] if_q[$];
    logic [32:0] ls_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    // Slave ready generator: fixed wait count when fixed_waits >= 0, else random.
    int fixed_waits = 0;
    int ready_pct   = 60;
    int wcnt        = 0;
    initial begin
        m_pready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (b_psel && b_penable) begin
                if (fixed_waits >= 0) begin
                    m_pready = (wcnt >= fixed_waits);
                    wcnt     = m_pready ? 0 : wcnt + 1;
                end else begin
                    m_pready = ($urandom_range(0, 99) < ready_pct);
                end
            end else begin
                wcnt     = 0;
                m_pready = 1'($urandom_range(0, 1));
            end
        end
    end

    // Transfer-level reference: at most one downstream transfer in flight.
    bit          x_active = 1'b0;
    bit          x_ls     = 1'b0;   // in-flight transfer belongs to LS
    int          x_age    = 0;      // 0 = first (setup) cycle, >0 = access cycles
    bit          last_ls  = 1'b1;
    logic [31:0] c_addr, c_wdata;
    logic        c_write;
    logic [3:0]  c_strb;
    logic [70:0] exp_bus;
    logic [67:0] exp_resp;
    logic [1:0]  exp_gnt;
    logic [32:0] sb_e;
    bit          cand_if, cand_ls, arb_now, win_ls;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (reset_n !== 1'b1) begin
                x_active = 1'b0;
                last_ls  = 1'b1;
                if_q.delete();
                ls_q.delete();
                continue;
            end
            exp_bus  = '0;
            exp_resp = '0;
            exp_gnt  = 2'b00;
            if (x_active) begin
                exp_bus = {1'b1, (x_age > 0), c_addr, c_write, c_wdata, c_strb};
                exp_gnt = x_ls ? 2'b10 : 2'b01;
                if (x_age > 0 && m_pready) begin
                    if (x_ls) exp_resp[33:0]  = {1'b1, rd_data(c_addr), err_f(c_addr)};
                    else      exp_resp[67:34] = {1'b1, rd_data(c_addr), err_f(c_addr)};
                end
            end
            check("bus", {b_psel, b_penable, b_paddr, b_pwrite, b_pwdata, b_pstrb}, exp_bus);
            check("resp", {b_if_pready, b_if_prdata, b_if_pslverr,
                           b_ls_pready, b_ls_prdata, b_ls_pslverr}, exp_resp);
            check("gnt", b_gnt, exp_gnt);

            if (b_if_pready === 1'b1) begin
                if (if_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL if_sb t=%0t actual=unexpected_pready required=none", $time);
                end else begin
                    sb_e = if_q.pop_front();
                    check("if_sb", {b_if_prdata, b_if_pslverr}, sb_e);
                end
            end
            if (b_ls_pready === 1'b1) begin
                if (ls_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL ls_sb t=%0t actual=unexpected_pready required=none", $time);
                end else begin
                    sb_e = ls_q.pop_front();
                    check("ls_sb", {b_ls_prdata, b_ls_pslverr}, sb_e);
                end
            end

            // Decide what the bus carries next cycle.
            arb_now = 1'b0;
            cand_if = 1'b0;
            cand_ls = 1'b0;
            if (x_active && x_age > 0 && m_pready) begin
                last_ls  = x_ls;
                x_active = 1'b0;
                arb_now  = 1'b1;
                cand_if  = if_psel && x_ls;
                cand_ls  = ls_psel && !x_ls;
            end else if (x_active) begin
                x_age++;
            end else begin
                arb_now = 1'b1;
                cand_if = if_psel;
                cand_ls = ls_psel;
            end
            if (arb_now && (cand_if || cand_ls)) begin
                win_ls   = cand_ls && (!cand_if || sel || !last_ls);
                x_active = 1'b1;
                x_ls     = win_ls;
                x_age    = 0;
                if (win_ls) begin
                    c_addr = ls_paddr; c_write = ls_pwrite; c_wdata = ls_pwdata; c_strb = ls_pstrb;
                end else begin
                    c_addr = if_paddr; c_write = 1'b0; c_wdata = '0; c_strb = '0;
                end
            end
        end
    end

    // Requester drivers: start at posedge+1, return at posedge+1 after completion.
    task automatic if_xfer(input logic [31:0] a, output int lat);
        bit seen = 1'b0;
        lat = 0;
        if_psel = 1'b1; if_paddr = a;
        if_q.push_back({rd_data(a), err_f(a)});
        while (!seen && lat < 200) begin
            @(negedge clk); lat++;
            seen = (b_if_pready === 1'b1);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL if_timeout addr=%h actual=no_pready required=pready", a);
        end
        @(posedge clk); #1;
        if_psel = 1'b0; if_paddr = '0;
    endtask

    task automatic ls_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] s, output int lat);
        bit seen = 1'b0;
        lat = 0;
        ls_psel = 1'b1; ls_paddr = a; ls_pwrite = w; ls_pwdata = d; ls_pstrb = s;
        ls_q.push_back({rd_data(a), err_f(a)});
        while (!seen && lat < 200) begin
            @(negedge clk); lat++;
            seen = (b_ls_pready === 1'b1);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL ls_timeout addr=%h actual=no_pready required=pready", a);
        end
        @(posedge clk); #1;
        ls_psel = 1'b0; ls_paddr = '0; ls_pwrite = 1'b0; ls_pwdata = '0; ls_pstrb = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset(input logic s);
        reset_n = 1'b0; sel = s;
        if_psel = 1'b0; if_paddr = '0;
        ls_psel = 1'b0; ls_paddr = '0; ls_pwrite = 1'b0; ls_pwdata = '0; ls_pstrb = '0;
        idle(2);
        reset_n = 1'b1;
        idle(1);
    endtask

    task automatic run_random(input int n);
        fork
            for (int i = 0; i < n; i++) begin
                int lat;
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                if_xfer($urandom & 32'hFFFF_FFFC, lat);
            end
            for (int j = 0; j < n; j++) begin
                int lat;
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                ls_xfer($urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)), $urandom,
                        4'($urandom), lat);
            end
        join
    endtask

    initial begin : stimulus
        int l1, l2;
        reset_n = 1'b0; sel = 1'b0;
        if_psel = 1'b0; if_paddr = '0;
        ls_psel = 1'b0; ls_paddr = '0; ls_pwrite = 1'b0; ls_pwdata = '0; ls_pstrb = '0;
        idle(3);
        reset_n = 1'b1;
        idle(1);

        // IF alone, slave ready at first ACCESS: pready two cycles after request.
        fixed_waits = 0;
        if_xfer(32'h100, l1);
        check("if_latency", l1, 3);
        idle(2);

        // Simultaneous requests after reset, round-robin.
        do_reset(1'b0);
        fork
            if_xfer(32'h200, l1);
            ls_xfer(32'h300, 1'b0, 32'h0, 4'h0, l2);
        join
        check("tie_if_first", l1, 3);
        check("tie_ls_second", l2, 5);
        idle(1);
        if_xfer(32'h204, l1);
        fork
            if_xfer(32'h208, l1);
            ls_xfer(32'h304, 1'b1, 32'h1234_5678, 4'h3, l2);
        join
        check("tie_ls_wins", l2, 3);
        idle(2);

        // LS write with three wait states.
        fixed_waits = 3;
        ls_xfer(32'h2000, 1'b1, 32'hDEAD_BEEF, 4'hF, l2);
        check("ls_wait_latency", l2, 6);
        fixed_waits = 0;
        idle(2);

        // Slave error on an LS read.
        ls_xfer(32'h3E0, 1'b0, 32'h0, 4'h0, l2);
        idle(2);

        // Reset while ACCESS is stalled.
        fixed_waits = 10;
        ls_psel = 1'b1; ls_paddr = 32'h4000; ls_pwrite = 1'b0; ls_pwdata = '0; ls_pstrb = '0;
        ls_q.push_back({rd_data(32'h4000), err_f(32'h4000)});
        l1 = 0;
        do begin @(negedge clk); l1++; end while (b_penable !== 1'b1 && l1 < 10);
        check("reach_access", b_penable, 1'b1);
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        ls_psel = 1'b0; ls_paddr = '0;
        fixed_waits = 0;
        @(negedge clk);
        check("rst_gnt", b_gnt, 2'b00);
        check("rst_bus", {b_psel, b_penable, b_paddr, b_pwrite, b_pwdata, b_pstrb}, 71'd0);
        @(posedge clk); #1;
        if_xfer(32'h100, l1);
        check("restart_latency", l1, 3);
        idle(2);

        // LS priority instance: both requesting continuously.
        do_reset(1'b1);
        fork
            for (int i = 0; i < 4; i++) begin
                int lat;
                if_xfer(32'h500 + 32'(i * 4), lat);
            end
            for (int j = 0; j < 4; j++) begin
                int lat;
                ls_xfer(32'h600 + 32'(j * 4), 1'b1, 32'hA0 + 32'(j), 4'hF, lat);
            end
        join
        idle(2);

        // Randomised traffic on both instances.
        fixed_waits = -1;
        for (int p = 0; p < 2; p++) begin
            do_reset(1'(p));
            ready_pct = (p == 0) ? 60 : 35;
            run_random(30);
            idle(3);
            check("if_q_empty", if_q.size(), 0);
            check("ls_q_empty", ls_q.size(), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
